// File: rtl/process_scheduler.sv
// process_scheduler
//   Round-robin process scheduler for the multi-process MIPS datapath.
//   Keeps the ready table, owns the running PID, decides when to preempt
//   (exit_proc > yield > timer_int > quantum expiry) and runs a req/ack
//   context-switch handshake with the PC/context-save logic. PID 0 is the
//   OS/BIOS process and is chosen whenever no user process is ready.
//
//   Optional feature macro: SCHED_QUANTUM_EN
//     defined   : quantum register, instruction counter and expiry event
//     undefined : quantum_we/quantum_in/step unused, quantum_left tied to 0
//
//   Ports
//     clock, reset          clock and synchronous active-high reset
//     step                  one instruction retired (quantum clock-enable)
//     timer_int, yield      preemption requests
//     exit_proc             running process halted; its ready bit is cleared
//     set_ready/set_pid/set_val  ready-table write port (bit 0 is fixed at 1)
//     quantum_we/quantum_in quantum register write (0 disables expiry)
//     switch_ack            datapath finished saving the old context
//     cur_pid, next_pid     running PID / switch target (valid with switch_req)
//     switch_req            context switch requested
//     ready_mask            ready table
//     quantum_left          remaining slice
module process_scheduler #(
  parameter int          NPROC       = 8,
  parameter int          PID_W       = 3,
  parameter logic [15:0] QUANTUM_DEF = 16'd64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             timer_int,
  input  logic             yield,
  input  logic             exit_proc,
  input  logic             set_ready,
  input  logic [PID_W-1:0] set_pid,
  input  logic             set_val,
  input  logic             quantum_we,
  input  logic [15:0]      quantum_in,
  input  logic             switch_ack,
  output logic [PID_W-1:0] cur_pid,
  output logic [PID_W-1:0] next_pid,
  output logic             switch_req,
  output logic [NPROC-1:0] ready_mask,
  output logic [15:0]      quantum_left
);

  typedef enum logic [1:0] {RUN, PICK, REQ} state_t;

  state_t           state;
  logic [PID_W-1:0] winner;
  logic [NPROC-1:0] ready_nxt;
  logic             expire;
  logic             sched_event;

  // Round-robin scan starting just after cur_pid; the last index visited is
  // cur_pid itself, so a lone ready current process re-selects itself.
  // NPROC is a power of two, so PID_W-bit addition wraps naturally.
  function automatic logic [PID_W-1:0] pick_next(input logic [NPROC-1:0] rdy,
                                                 input logic [PID_W-1:0] cur);
    logic [PID_W-1:0] idx;
    logic             found;
    pick_next = '0;
    found     = 1'b0;
    for (int i = 1; i <= NPROC; i++) begin
      idx = cur + PID_W'(i);
      if (!found && (idx != '0) && rdy[idx]) begin
        pick_next = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign winner = pick_next(ready_mask, cur_pid);

  // All event sources lead to the same PICK step; priority only matters for
  // exit_proc, whose ready-bit clear is handled in the ready-table update.
  assign sched_event = (state == RUN) && (exit_proc || yield || timer_int || expire);

  // Ready table: writes accepted in any state, exit_proc overrides a
  // same-cycle write to cur_pid, bit 0 is pinned high.
  always_comb begin
    ready_nxt = ready_mask;
    if (set_ready)
      ready_nxt[set_pid] = set_val;
    if ((state == RUN) && exit_proc)
      ready_nxt[cur_pid] = 1'b0;
    ready_nxt[0] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      ready_mask <= NPROC'(1);
    else
      ready_mask <= ready_nxt;
  end

  // Scheduler FSM: RUN -> PICK -> (RUN | REQ -> RUN)
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      cur_pid    <= '0;
      next_pid   <= '0;
      switch_req <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (sched_event)
            state <= PICK;
        end
        PICK: begin
          if (winner == cur_pid) begin
            state <= RUN;
          end else begin
            next_pid   <= winner;
            switch_req <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // next_pid stays frozen; later ready-table changes cannot abort.
          if (switch_ack) begin
            cur_pid    <= next_pid;
            switch_req <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef SCHED_QUANTUM_EN
  logic [15:0] quantum_reg;
  logic [15:0] quantum_cnt;
  logic        reload;

  assign reload       = ((state == PICK) && (winner == cur_pid)) ||
                        ((state == REQ) && switch_ack);
  // A zero counter never expires, which is how quantum 0 disables preemption.
  assign expire       = step && (quantum_cnt == 16'd1);
  assign quantum_left = quantum_cnt;

  // New quantum values take effect only at the next reload.
  always_ff @(posedge clock) begin
    if (reset) begin
      quantum_reg <= QUANTUM_DEF;
      quantum_cnt <= QUANTUM_DEF;
    end else begin
      if (quantum_we)
        quantum_reg <= quantum_in;
      if (reload)
        quantum_cnt <= quantum_reg;
      else if ((state == RUN) && step && (quantum_cnt != 16'd0))
        quantum_cnt <= quantum_cnt - 16'd1;
    end
  end
`else
  logic unused_quantum;

  assign unused_quantum = ^{step, quantum_we, quantum_in};
  assign expire         = 1'b0;
  assign quantum_left   = 16'd0;
`endif

endmodule
